// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  // Transmit FSM states, in frame order.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL      = 1'b1;
  localparam int   UART_DATA_BITS       = 8;
  localparam int   DEFAULT_CLKS_PER_BIT = 10417;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO between the register slave and the serialiser. Owns storage,
// wrap-around pointers, the level count, full/empty flags and the sticky
// overflow flag. Full/empty are registered and derived from the count.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       head,
  input  logic             clr_overflow,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             push_ok;
  logic             pop_ok;

  // Accept decisions use the registered flags, so a pop never frees a slot
  // for a push in the same cycle and a fresh byte cannot be popped at once.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Level after this cycle's accepted push/pop.
  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + CNT_W'(1);
    end else if (!push_ok && pop_ok) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, level, flags and sticky overflow (set wins over clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
      if (push && full) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_uart_tx_engine.sv
// UART 8N1 transmit engine: buffers bytes pushed by the register slave and
// serialises them LSB first. Handshake: i_wr_en is a one-cycle push strobe
// with no ready; o_full (registered) is the only back-pressure, and a strobe
// seen while o_full=1 is dropped and recorded in the sticky o_overflow.
module axi_uart_tx_engine
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter  int FIFO_DEPTH   = 16,
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic             i_wr_en,
  input  logic [7:0]       i_wr_data,
  input  logic             i_clr_overflow,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_fifo_count,
  output logic             o_overflow,
  output logic             o_tx_serial,
  output logic             o_tx_active,
  output logic             o_tx_done,
  output tx_state_t        dbg_state
);

  localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

  tx_state_t        state, state_n;
  logic [CYC_W-1:0] cyc, cyc_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             serial_q, serial_n;
  logic             active_q, active_n;
  logic             done_q, done_n;
  logic             pop;
  logic [7:0]       head;
  logic             last_cyc;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (S_AXI_ACLK),
    .rst_n        (S_AXI_ARESETN),
    .push         (i_wr_en),
    .push_data    (i_wr_data),
    .pop          (pop),
    .head         (head),
    .clr_overflow (i_clr_overflow),
    .full         (o_full),
    .empty        (o_empty),
    .count        (o_fifo_count),
    .overflow     (o_overflow)
  );

  assign last_cyc    = (cyc == CYC_LAST);
  assign o_tx_serial = serial_q;
  assign o_tx_active = active_q;
  assign o_tx_done   = done_q;
  assign dbg_state   = state;

  // FSM state, counters, shift register and registered line outputs.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state    <= IDLE;
      cyc      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      serial_q <= UART_IDLE_LEVEL;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cyc      <= cyc_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      serial_q <= serial_n;
      active_q <= active_n;
      done_q   <= done_n;
    end
  end

  // Next-state and next-output logic; line values are computed one edge
  // ahead so the pin itself comes straight from a flop.
  always_comb begin
    state_n   = state;
    cyc_n     = cyc;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    serial_n  = serial_q;
    active_n  = active_q;
    done_n    = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        serial_n  = UART_IDLE_LEVEL;
        active_n  = 1'b0;
        cyc_n     = '0;
        bit_idx_n = '0;
        if (!o_empty) begin
          pop      = 1'b1;
          shreg_n  = head;
          state_n  = START;
          serial_n = ~UART_IDLE_LEVEL;
          active_n = 1'b1;
        end
      end
      START: begin
        if (last_cyc) begin
          state_n   = DATA;
          cyc_n     = '0;
          bit_idx_n = '0;
          serial_n  = shreg[0];
        end else begin
          cyc_n = cyc + CYC_W'(1);
        end
      end
      DATA: begin
        if (last_cyc) begin
          cyc_n = '0;
          if (bit_idx == BIT_LAST) begin
            state_n  = STOP;
            serial_n = UART_IDLE_LEVEL;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = shreg >> 1;
            serial_n  = shreg[1];
          end
        end else begin
          cyc_n = cyc + CYC_W'(1);
        end
      end
      STOP: begin
        if (last_cyc) begin
          state_n  = IDLE;
          cyc_n    = '0;
          done_n   = 1'b1;
          active_n = 1'b0;
          serial_n = UART_IDLE_LEVEL;
        end else begin
          cyc_n = cyc + CYC_W'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        serial_n = UART_IDLE_LEVEL;
        active_n = 1'b0;
      end
    endcase
  end

endmodule
